// File: rtl/demux_pkg.sv
// Shared types and constants for the 1-to-2 packet-aware stream demultiplexer.
package demux_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam logic LANE0 = 1'b0;
  localparam logic LANE1 = 1'b1;

endpackage

// File: rtl/demux_out_reg.sv
// One-entry valid/ready output register holding a data beat and its last flag.
module demux_out_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d_data,
  input  logic             d_last,
  output logic             q_valid,
  input  logic             q_ready,
  output logic [WIDTH-1:0] q_data,
  output logic             q_last,
  output logic             empty_or_draining
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             last_q, last_d;

  assign empty_or_draining = !valid_q || q_ready;
  assign q_valid = valid_q;
  assign q_data  = data_q;
  assign q_last  = last_q;

  // A load in the same cycle as a drain wins, keeping the lane at full rate.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = d_data;
      last_d  = d_last;
    end else if (valid_q && q_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: rtl/demux1_2.sv
// Registered 1-to-2 stream demultiplexer; the lane is locked for the whole packet.
module demux1_2
  import demux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  input  logic             in_sel,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_last,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_last,
  output logic             out1_valid,
  input  logic             out1_ready
);

  state_e state_q, state_d;
  logic   lock_sel_q, lock_sel_d;
  logic   route, xfer, load0, load1;
  logic   lane0_free, lane1_free;

  // Only the routed lane gates the input; the other lane may stall freely.
  always_comb begin
    route    = (state_q == BUSY) ? lock_sel_q : in_sel;
    in_ready = (route == LANE1) ? lane1_free : lane0_free;
    xfer     = in_valid && in_ready;
    load0    = xfer && (route == LANE0);
    load1    = xfer && (route == LANE1);
  end

  always_comb begin
    state_d    = state_q;
    lock_sel_d = lock_sel_q;
    if (xfer) begin
      if (state_q == IDLE && !in_last) begin
        state_d    = BUSY;
        lock_sel_d = in_sel;
      end else if (state_q == BUSY && in_last) begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      lock_sel_q <= LANE0;
    end else begin
      state_q    <= state_d;
      lock_sel_q <= lock_sel_d;
    end
  end

  demux_out_reg #(.WIDTH(WIDTH)) u_lane0 (
    .clk               (clk),
    .rst               (rst),
    .load              (load0),
    .d_data            (in_data),
    .d_last            (in_last),
    .q_valid           (out0_valid),
    .q_ready           (out0_ready),
    .q_data            (out0_data),
    .q_last            (out0_last),
    .empty_or_draining (lane0_free)
  );

  demux_out_reg #(.WIDTH(WIDTH)) u_lane1 (
    .clk               (clk),
    .rst               (rst),
    .load              (load1),
    .d_data            (in_data),
    .d_last            (in_last),
    .q_valid           (out1_valid),
    .q_ready           (out1_ready),
    .q_data            (out1_data),
    .q_last            (out1_last),
    .empty_or_draining (lane1_free)
  );

endmodule

// File: tb/tb_demux1_2.sv
// Self-checking bench for demux1_2: directed scenarios plus randomized traffic against a packet-level model.
module tb_demux1_2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       in_sel = 1'b0;
  logic       in_ready;
  logic [7:0] out0_data, out1_data;
  logic       out0_last, out1_last;
  logic       out0_valid, out1_valid;
  logic       out0_ready = 1'b1;
  logic       out1_ready = 1'b1;

  int tests_run = 0;
  int tests_failed = 0;

  // Model: each lane holds at most one beat; a packet owns one lane from first to last beat.
  bit       m_valid [2];
  bit [7:0] m_data  [2];
  bit       m_last  [2];
  bit       m_in_packet;
  bit       m_packet_lane;

  always #5 clk = ~clk;

  demux1_2 #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_sel     (in_sel),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out0_last  (out0_last),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_last  (out1_last),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready)
  );

  function automatic bit model_lane();
    return m_in_packet ? m_packet_lane : in_sel;
  endfunction

  function automatic bit model_ready();
    bit [1:0] consumer;
    consumer = {out1_ready, out0_ready};
    return !m_valid[model_lane()] || consumer[model_lane()];
  endfunction

  task automatic model_step();
    bit [1:0] consumer;
    bit       lane;
    bit       accept;
    consumer = {out1_ready, out0_ready};
    if (rst) begin
      for (int l = 0; l < 2; l++) begin
        m_valid[l] = 0;
        m_data[l]  = 0;
        m_last[l]  = 0;
      end
      m_in_packet   = 0;
      m_packet_lane = 0;
    end else begin
      lane   = model_lane();
      accept = in_valid && model_ready();
      for (int l = 0; l < 2; l++)
        if (m_valid[l] && consumer[l]) m_valid[l] = 0;
      if (accept) begin
        m_valid[lane] = 1;
        m_data[lane]  = in_data;
        m_last[lane]  = in_last;
        if (!m_in_packet && !in_last) begin
          m_in_packet   = 1;
          m_packet_lane = in_sel;
        end else if (m_in_packet && in_last) begin
          m_in_packet = 0;
        end
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input bit v, input bit sel, input bit [7:0] d, input bit last);
    in_valid = v;
    in_sel   = sel;
    in_data  = d;
    in_last  = last;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 1'b1, 8'hFF, 1'b0);
    cycle();
    cycle();
    tests_run++;
    if ({out0_valid, out1_valid} !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL reset_valid got %b expected 00", {out0_valid, out1_valid});
    end
    tests_run++;
    if ({out0_data, out1_data} !== 16'h0000) begin
      tests_failed++;
      $display("[TB] FAIL reset_data got %h expected 0000", {out0_data, out1_data});
    end
    rst = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_in_ready got %b expected 1", in_ready);
    end
    tests_run++;
    if ({out0_valid, out1_valid, out0_data, out1_data} !== 18'h0) begin
      tests_failed++;
      $display("[TB] FAIL post_reset_outputs got %h expected 0", {out0_valid, out1_valid, out0_data, out1_data});
    end
    cycle();
  endtask

  task automatic test_single_beat();
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    drive(1'b1, 1'b1, 8'hA5, 1'b1);
    cycle();
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    tests_run++;
    if ({out1_valid, out1_data, out1_last} !== {1'b1, 8'hA5, 1'b1}) begin
      tests_failed++;
      $display("[TB] FAIL single_lane1 got v=%b d=%h l=%b expected v=1 d=a5 l=1", out1_valid, out1_data, out1_last);
    end
    tests_run++;
    if (out0_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL single_lane0_idle got %b expected 0", out0_valid);
    end
    cycle();
  endtask

  task automatic test_multi_beat();
    bit [7:0] beats [3];
    bit       sels  [3];
    beats = '{8'h11, 8'h22, 8'h33};
    sels  = '{1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, sels[i], beats[i], i == 2);
      cycle();
      tests_run++;
      if ({out0_valid, out0_data, out0_last} !== {1'b1, beats[i], i == 2}) begin
        tests_failed++;
        $display("[TB] FAIL multi_beat%0d got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                 i, out0_valid, out0_data, out0_last, beats[i], i == 2);
      end
      tests_run++;
      if (out1_valid !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL multi_lane1_idle%0d got %b expected 0", i, out1_valid);
      end
    end
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    cycle();
  endtask

  task automatic test_backpressure();
    out0_ready = 1'b0;
    drive(1'b1, 1'b0, 8'h5A, 1'b1);
    cycle();
    drive(1'b1, 1'b0, 8'h77, 1'b1);
    #1;
    tests_run++;
    if (in_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL bp_in_ready got %b expected 0", in_ready);
    end
    cycle();
    tests_run++;
    if ({out0_valid, out0_data} !== {1'b1, 8'h5A}) begin
      tests_failed++;
      $display("[TB] FAIL bp_hold got v=%b d=%h expected v=1 d=5a", out0_valid, out0_data);
    end
    out0_ready = 1'b1;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL bp_release_ready got %b expected 1", in_ready);
    end
    cycle();
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    tests_run++;
    if ({out0_valid, out0_data} !== {1'b1, 8'h77}) begin
      tests_failed++;
      $display("[TB] FAIL bp_no_bubble got v=%b d=%h expected v=1 d=77", out0_valid, out0_data);
    end
    cycle();
  endtask

  task automatic test_independent_lanes();
    out1_ready = 1'b0;
    drive(1'b1, 1'b1, 8'h99, 1'b1);
    cycle();
    drive(1'b1, 1'b0, 8'h44, 1'b1);
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL indep_ready got %b expected 1", in_ready);
    end
    cycle();
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    tests_run++;
    if ({out0_valid, out0_data} !== {1'b1, 8'h44}) begin
      tests_failed++;
      $display("[TB] FAIL indep_lane0 got v=%b d=%h expected v=1 d=44", out0_valid, out0_data);
    end
    cycle();
    tests_run++;
    if ({out1_valid, out1_data, out1_last} !== {1'b1, 8'h99, 1'b1}) begin
      tests_failed++;
      $display("[TB] FAIL indep_lane1_hold got v=%b d=%h l=%b expected v=1 d=99 l=1", out1_valid, out1_data, out1_last);
    end
    out1_ready = 1'b1;
    cycle();
  endtask

  task automatic test_reset_mid_packet();
    drive(1'b1, 1'b1, 8'hC3, 1'b0);
    cycle();
    rst = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    cycle();
    rst = 1'b0;
    tests_run++;
    if ({out0_valid, out1_valid} !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL midreset_valid got %b expected 00", {out0_valid, out1_valid});
    end
    drive(1'b1, 1'b0, 8'hD4, 1'b1);
    cycle();
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    tests_run++;
    if ({out0_valid, out0_data, out1_valid} !== {1'b1, 8'hD4, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL midreset_reroute got v0=%b d0=%h v1=%b expected v0=1 d0=d4 v1=0", out0_valid, out0_data, out1_valid);
    end
    cycle();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rst        = ($urandom_range(63) == 0);
      in_valid   = ($urandom_range(9) < 7);
      in_sel     = $urandom_range(1);
      in_last    = ($urandom_range(3) == 0);
      in_data    = 8'($urandom);
      out0_ready = ($urandom_range(3) != 0);
      out1_ready = ($urandom_range(3) != 0);
      #1;
      tests_run++;
      if (in_ready !== model_ready()) begin
        tests_failed++;
        $display("[TB] FAIL rand_in_ready n=%0d got %b expected %b", n, in_ready, model_ready());
      end
      cycle();
      tests_run++;
      if ({out1_valid, out0_valid} !== {m_valid[1], m_valid[0]}) begin
        tests_failed++;
        $display("[TB] FAIL rand_valid n=%0d got %b expected %b", n, {out1_valid, out0_valid}, {m_valid[1], m_valid[0]});
      end
      if (m_valid[0]) begin
        tests_run++;
        if ({out0_data, out0_last} !== {m_data[0], m_last[0]}) begin
          tests_failed++;
          $display("[TB] FAIL rand_lane0 n=%0d got d=%h l=%b expected d=%h l=%b", n, out0_data, out0_last, m_data[0], m_last[0]);
        end
      end
      if (m_valid[1]) begin
        tests_run++;
        if ({out1_data, out1_last} !== {m_data[1], m_last[1]}) begin
          tests_failed++;
          $display("[TB] FAIL rand_lane1 n=%0d got d=%h l=%b expected d=%h l=%b", n, out1_data, out1_last, m_data[1], m_last[1]);
        end
      end
    end
    rst = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_multi_beat();
    test_backpressure();
    test_independent_lanes();
    test_reset_mid_packet();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/demux1_2.md
Name: demux1_2

Overview:
- Registered 1-to-2 stream demultiplexer: the inverse of the team's 2:1 mux.
- Routes each accepted input beat to lane 0 or lane 1, selected by `in_sel`.
- Uses valid/ready handshakes and one-entry output registers per lane.
- Packet-aware: the select is latched on the first beat of a packet and held until the beat carrying `in_last`, so packets are never split across lanes.
- Sits between a single producer and two independent consumers.

Parameters:
- WIDTH, 8, data width in bits of `in_data`, `out0_data` and `out1_data`.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- in_data  input  WIDTH  input beat data
- in_valid  input  1  input beat present
- in_last  input  1  input beat is the final beat of its packet
- in_sel  input  1  lane select, 0 = lane 0, 1 = lane 1; sampled only on the first beat of a packet
- in_ready  output  1  block accepts the beat this cycle
- out0_data  output  WIDTH  lane 0 data
- out0_last  output  1  lane 0 last flag
- out0_valid  output  1  lane 0 beat present
- out0_ready  input  1  lane 0 consumer accepts
- out1_data  output  WIDTH  lane 1 data
- out1_last  output  1  lane 1 last flag
- out1_valid  output  1  lane 1 beat present
- out1_ready  input  1  lane 1 consumer accepts

Behaviour:
- Clock and reset: single clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: `out0_valid`/`out1_valid` = 0, `out*_data` = 0, `out*_last` = 0, state = IDLE, `lock_sel` = 0. `in_ready` follows from the empty lane registers, so it is 1 on the first cycle after reset.
- Reset mid-packet discards all buffered beats and the packet lock.
- Route lane:
  - in IDLE, `route = in_sel`;
  - in BUSY, `route = lock_sel`.
- `in_ready` is 1 when the routed lane register is empty, or when it is full and its `outN_ready` = 1 in the same cycle. This is a combinational path from `outN_ready`.
- Transfer occurs when `in_valid && in_ready`. The beat's data and last flag are written to the routed lane register, which is valid on the next cycle. Latency is 1 cycle.
- Lane register rules:
  - drains when `outN_valid && outN_ready`;
  - a simultaneous drain and load keeps `outN_valid` = 1 with the new data, giving full throughput of 1 beat/cycle;
  - while `outN_valid && !outN_ready`, data and last hold stable.
- Lanes are independent: a stall on the non-routed lane never blocks the input.
- State machine:
  - IDLE → BUSY on a transfer with `in_last` = 0; `lock_sel <= in_sel`.
  - IDLE → IDLE on a transfer with `in_last` = 1 (single-beat packet); `lock_sel` is unchanged.
  - BUSY → IDLE on a transfer with `in_last` = 1.
  - BUSY otherwise holds; `in_sel` is ignored while BUSY.
  - No transfer means no state change.
- `in_valid` = 0 produces no write, regardless of the other inputs.
- Output data is never X after reset.

Decomposition:
- Shared package `demux_pkg`:
  - state encoding: IDLE = 1'b0, BUSY = 1'b1;
  - lane constants: LANE0 = 1'b0, LANE1 = 1'b1.
- Sub-module `demux_out_reg` (WIDTH parameter): a one-entry valid/ready register that holds data and last.
  - Ports: clk, rst, load, d_data, d_last, q_valid, q_ready, q_data, q_last, empty_or_draining.
  - Instantiated twice, once per lane.
- The top level contains only the FSM, the routing/select logic, and the `in_ready` logic.

Test Plan:
- Reset with `in_valid` = 1 held → both `out*_valid` = 0 and `out*_data` = 0 during reset and on the first cycle after reset, until a beat is accepted; `in_ready` = 1 once reset is released.
- Single-beat packet: `in_sel` = 1, `in_data` = 8'hA5, `in_last` = 1, both readies 1 → next cycle `out1_valid` = 1, `out1_data` = A5, `out1_last` = 1; `out0_valid` stays 0; state stays IDLE.
- Three-beat packet 11, 22, 33 with `in_sel` = 0 on beat 1, then `in_sel` = 1 on beats 2 and 3 → all three beats appear on lane 0 on consecutive cycles, with last only on 33; lane 1 stays idle.
- Backpressure: `out0_ready` = 0 with one beat 8'h5A buffered in lane 0, a lane 0 beat 8'h77 offered with `in_valid` = 1 → `in_ready` = 0 and `out0_data` holds 5A. Raise `out0_ready` → 5A transfers and the pending beat loads the same cycle, with no bubble.
- Independent lanes: lane 1 stalled and full, new packet 8'h44 with `in_sel` = 0 → accepted and delivered on lane 0; lane 1 contents unchanged.
- Reset mid-packet: after beat 1 of a lane 1 packet, assert `rst` → both valids 0 and state IDLE. The next packet with `in_sel` = 0 routes to lane 0.
